// File: rtl/disp_pkg.sv
// ============================================================================
// Package : disp_pkg
// Brief   : Shared types and glyph constants for the result display driver.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package disp_pkg;

  // Top-level controller states
  typedef enum logic [1:0] {
    BLANK = 2'd0,
    PEND  = 2'd1,
    SHOW  = 2'd2
  } state_t;

  // Segment patterns, seg[0]=a .. seg[6]=g, active-high
  localparam logic [6:0] GLYPH_0     = 7'b0111111;
  localparam logic [6:0] GLYPH_1     = 7'b0000110;
  localparam logic [6:0] GLYPH_2     = 7'b1011011;
  localparam logic [6:0] GLYPH_3     = 7'b1001111;
  localparam logic [6:0] GLYPH_4     = 7'b1100110;
  localparam logic [6:0] GLYPH_5     = 7'b1101101;
  localparam logic [6:0] GLYPH_6     = 7'b1111101;
  localparam logic [6:0] GLYPH_E     = 7'b1111001;
  localparam logic [6:0] GLYPH_MINUS = 7'b1000000;
  localparam logic [6:0] GLYPH_OFF   = 7'b0000000;

  // Both digit enables released (active-low)
  localparam logic [1:0] AN_OFF      = 2'b11;

endpackage : disp_pkg

`default_nettype wire

// File: rtl/seg7_glyph.sv
// ============================================================================
// Module  : seg7_glyph
// Brief   : Magnitude-to-segment decoder; error forces the 'E' glyph.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_glyph
  import disp_pkg::*;
(
  input  logic [2:0] magnitude,
  input  logic       err,
  output logic [6:0] glyph
);

  // Table lookup; magnitude 7 is never valid, so it shares the 'E' glyph
  always_comb begin
    glyph = GLYPH_E;
    if (!err) begin
      case (magnitude)
        3'd0:    glyph = GLYPH_0;
        3'd1:    glyph = GLYPH_1;
        3'd2:    glyph = GLYPH_2;
        3'd3:    glyph = GLYPH_3;
        3'd4:    glyph = GLYPH_4;
        3'd5:    glyph = GLYPH_5;
        3'd6:    glyph = GLYPH_6;
        default: glyph = GLYPH_E;
      endcase
    end
  end

endmodule : seg7_glyph

`default_nettype wire

// File: rtl/result_display.sv
// ============================================================================
// Module  : result_display
// Brief   : Two-digit multiplexed seven-segment driver for a sign-magnitude
//           result. Values are committed only at scan-frame boundaries so a
//           frame never mixes old and new digits.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module result_display
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] result,
  input  logic       zeroflag,
  input  logic       clear,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       zero_led,
  output logic       err
);

  localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  state_t           state;
  logic [DIV_W-1:0] div;
  logic             digit;

  // Captured-but-not-yet-committed value
  logic [4:0]       pend_result;
  logic             pend_zero;

  // Committed value being scanned; disp_valid is low until the first commit
  logic             disp_sign;
  logic [2:0]       disp_mag;
  logic             disp_valid;

  logic             term;
  logic             frame_bnd;
  logic             xfer;
  logic             pend_err;
  logic [6:0]       mag_glyph;
  logic [6:0]       sign_glyph;

  assign term      = (div == DIV_LAST);
  assign frame_bnd = term && digit;
  assign xfer      = in_valid && in_ready;

  // Consistency check of the pending value, evaluated at commit
  assign pend_err  = pend_result[3]
                   | (pend_result[2:0] == 3'd7)
                   | (pend_zero != (pend_result[2:0] == 3'd0));

  // A minus is only meaningful on a valid non-zero magnitude
  assign sign_glyph = (disp_sign && (disp_mag != 3'd0) && !err) ? GLYPH_MINUS : GLYPH_OFF;

  seg7_glyph u_glyph (
    .magnitude (disp_mag),
    .err       (err),
    .glyph     (mag_glyph)
  );

  // Free-running slot divider and digit index; clear does not disturb them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div   <= '0;
      digit <= 1'b0;
    end else if (term) begin
      div   <= '0;
      digit <= ~digit;
    end else begin
      div   <= div + 1'b1;
    end
  end

  // Handshake / commit FSM; clear outranks a same-cycle transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BLANK;
      in_ready    <= 1'b1;
      pend_result <= '0;
      pend_zero   <= 1'b0;
      disp_sign   <= 1'b0;
      disp_mag    <= '0;
      disp_valid  <= 1'b0;
      zero_led    <= 1'b0;
      err         <= 1'b0;
    end else if (clear) begin
      state       <= BLANK;
      in_ready    <= 1'b1;
      disp_valid  <= 1'b0;
      zero_led    <= 1'b0;
      err         <= 1'b0;
    end else if (xfer) begin
      state       <= PEND;
      in_ready    <= 1'b0;
      pend_result <= result;
      pend_zero   <= zeroflag;
    end else if ((state == PEND) && frame_bnd) begin
      state       <= SHOW;
      in_ready    <= 1'b1;
      disp_sign   <= pend_result[4];
      disp_mag    <= pend_result[2:0];
      disp_valid  <= 1'b1;
      zero_led    <= pend_zero;
      err         <= pend_err;
    end
  end

  // Registered digit drive; a clear blanks on the same edge it takes effect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= GLYPH_OFF;
      an  <= AN_OFF;
    end else if (clear || !disp_valid) begin
      seg <= GLYPH_OFF;
      an  <= AN_OFF;
    end else if (!digit) begin
      seg <= mag_glyph;
      an  <= 2'b10;
    end else begin
      seg <= sign_glyph;
      an  <= 2'b01;
    end
  end

endmodule : result_display

`default_nettype wire

// File: tb/tb_result_display.sv
// ============================================================================
// Module  : tb_result_display
// Brief   : Directed self-checking bench for result_display, REFRESH_DIV=4.
//           Frame boundaries fall on every 8th rising edge after reset release.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_result_display;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] result;
  logic       zeroflag;
  logic       clear;
  logic [6:0] seg;
  logic [1:0] an;
  logic       zero_led;
  logic       err;

  int n_vec = 0;
  int n_err = 0;
  int cyc;

  result_display #(.REFRESH_DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .result   (result),
    .zeroflag (zeroflag),
    .clear    (clear),
    .seg      (seg),
    .an       (an),
    .zero_led (zero_led),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges seen since the last reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance to 1 time unit after rising edge number c
  task automatic to_cycle(input int c);
    int guard = 0;
    while (cyc < c && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc != c) begin
      n_vec++;
      n_err++;
      $error("FAIL to_cycle: observed cycle %0d expected %0d", cyc, c);
    end
  endtask

  task automatic present(input logic [4:0] r, input logic z);
    result   = r;
    zeroflag = z;
    in_valid = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    result   = '0;
    zeroflag = 1'b0;
    clear    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an",       {6'd0, an},       8'b11);
    chk("rst_seg",      {1'b0, seg},      8'h00);
    chk("rst_ready",    {7'd0, in_ready}, 8'd1);
    chk("rst_zero_led", {7'd0, zero_led}, 8'd0);
    chk("rst_err",      {7'd0, err},      8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First frame stays blank and ready
    for (int i = 1; i <= 8; i++) begin
      to_cycle(i);
      chk("frame0_an",    {6'd0, an},       8'b11);
      chk("frame0_seg",   {1'b0, seg},      8'h00);
      chk("frame0_ready", {7'd0, in_ready}, 8'd1);
    end

    // -3: transfer at edge 9, commit at boundary edge 16
    present(5'b10011, 1'b0);
    to_cycle(9);
    in_valid = 1'b0;
    for (int i = 9; i <= 15; i++) begin
      to_cycle(i);
      chk("m3_ready_low", {7'd0, in_ready}, 8'd0);
    end
    to_cycle(16);
    chk("m3_ready_high", {7'd0, in_ready}, 8'd1);
    chk("m3_err",        {7'd0, err},      8'd0);
    chk("m3_zero_led",   {7'd0, zero_led}, 8'd0);
    chk("m3_an_commit",  {6'd0, an},       8'b11);
    to_cycle(17);
    chk("m3_an_mag",  {6'd0, an},  8'b10);
    chk("m3_seg_mag", {1'b0, seg}, {1'b0, 7'b1001111});
    to_cycle(20);
    chk("m3_an_mag_hold", {6'd0, an}, 8'b10);
    to_cycle(21);
    chk("m3_an_sign",  {6'd0, an},  8'b01);
    chk("m3_seg_sign", {1'b0, seg}, {1'b0, 7'b1000000});
    to_cycle(25);
    chk("m3_an_mag2", {6'd0, an}, 8'b10);

    // Negative zero: transfer at 26, commit at 32, old value held meanwhile
    present(5'b10000, 1'b1);
    to_cycle(26);
    in_valid = 1'b0;
    to_cycle(30);
    chk("nz_old_an",  {6'd0, an},  8'b01);
    chk("nz_old_seg", {1'b0, seg}, {1'b0, 7'b1000000});
    to_cycle(32);
    chk("nz_zero_led", {7'd0, zero_led}, 8'd1);
    chk("nz_err",      {7'd0, err},      8'd0);
    to_cycle(33);
    chk("nz_an_mag",  {6'd0, an},  8'b10);
    chk("nz_seg_mag", {1'b0, seg}, {1'b0, 7'b0111111});
    to_cycle(37);
    chk("nz_an_sign",  {6'd0, an},  8'b01);
    chk("nz_seg_sign", {1'b0, seg}, 8'h00);

    // +5 flagged zero: inconsistent, commit at 48
    to_cycle(40);
    present(5'b00101, 1'b1);
    to_cycle(41);
    in_valid = 1'b0;
    to_cycle(48);
    chk("inc_err",      {7'd0, err},      8'd1);
    chk("inc_zero_led", {7'd0, zero_led}, 8'd1);
    to_cycle(49);
    chk("inc_seg_mag", {1'b0, seg}, {1'b0, 7'b1111001});
    to_cycle(53);
    chk("inc_an_sign",  {6'd0, an},  8'b01);
    chk("inc_seg_sign", {1'b0, seg}, 8'h00);

    // +2 committed at 64, then +4 transferred two edges after the boundary
    to_cycle(56);
    present(5'b00010, 1'b0);
    to_cycle(57);
    in_valid = 1'b0;
    to_cycle(65);
    chk("two_seg", {1'b0, seg}, {1'b0, 7'b1011011});
    chk("two_err", {7'd0, err}, 8'd0);
    present(5'b00100, 1'b0);
    to_cycle(66);
    in_valid = 1'b0;
    to_cycle(67);
    chk("four_ready_low", {7'd0, in_ready}, 8'd0);
    chk("two_persist_an", {6'd0, an},       8'b10);
    chk("two_persist",    {1'b0, seg},      {1'b0, 7'b1011011});
    to_cycle(71);
    chk("two_sign_an",  {6'd0, an},  8'b01);
    chk("two_sign_off", {1'b0, seg}, 8'h00);
    to_cycle(72);
    chk("four_ready_high", {7'd0, in_ready}, 8'd1);
    to_cycle(73);
    chk("four_an",  {6'd0, an},  8'b10);
    chk("four_seg", {1'b0, seg}, {1'b0, 7'b1100110});

    // clear collides with a transfer at edge 74; the transfer is dropped
    present(5'b00001, 1'b0);
    clear = 1'b1;
    to_cycle(74);
    in_valid = 1'b0;
    clear    = 1'b0;
    chk("clr_an",    {6'd0, an},       8'b11);
    chk("clr_seg",   {1'b0, seg},      8'h00);
    chk("clr_ready", {7'd0, in_ready}, 8'd1);
    to_cycle(81);
    chk("clr_no_commit_an",    {6'd0, an},       8'b11);
    chk("clr_no_commit_ready", {7'd0, in_ready}, 8'd1);
    to_cycle(85);
    chk("clr_no_commit_an2", {6'd0, an}, 8'b11);

    // Transfer on boundary edge 88 must wait for boundary 96
    to_cycle(87);
    present(5'b00110, 1'b0);
    to_cycle(88);
    in_valid = 1'b0;
    chk("bnd_ready_low", {7'd0, in_ready}, 8'd0);
    to_cycle(89);
    chk("bnd_still_blank", {6'd0, an}, 8'b11);
    to_cycle(95);
    chk("bnd_ready_low2", {7'd0, in_ready}, 8'd0);
    to_cycle(96);
    chk("bnd_ready_high", {7'd0, in_ready}, 8'd1);
    to_cycle(97);
    chk("six_an",  {6'd0, an},  8'b10);
    chk("six_seg", {1'b0, seg}, {1'b0, 7'b1111101});
    chk("six_err", {7'd0, err}, 8'd0);

    // Magnitude 7 is out of range
    present(5'b00111, 1'b0);
    to_cycle(98);
    in_valid = 1'b0;
    to_cycle(104);
    chk("m7_err", {7'd0, err}, 8'd1);
    to_cycle(105);
    chk("m7_seg", {1'b0, seg}, {1'b0, 7'b1111001});

    // Reset while pending
    present(5'b01001, 1'b0);
    to_cycle(106);
    in_valid = 1'b0;
    to_cycle(107);
    chk("pre_rst_ready", {7'd0, in_ready}, 8'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_an",       {6'd0, an},       8'b11);
    chk("mid_rst_seg",      {1'b0, seg},      8'h00);
    chk("mid_rst_ready",    {7'd0, in_ready}, 8'd1);
    chk("mid_rst_err",      {7'd0, err},      8'd0);
    chk("mid_rst_zero_led", {7'd0, zero_led}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Bit 3 set is an error even with a consistent zero flag
    to_cycle(1);
    present(5'b01001, 1'b0);
    to_cycle(2);
    in_valid = 1'b0;
    to_cycle(7);
    chk("b3_ready_low", {7'd0, in_ready}, 8'd0);
    to_cycle(8);
    chk("b3_err", {7'd0, err}, 8'd1);
    to_cycle(9);
    chk("b3_an",  {6'd0, an},  8'b10);
    chk("b3_seg", {1'b0, seg}, {1'b0, 7'b1111001});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_result_display

`default_nettype wire
